// File: rtl/intc_pkg.sv
// intc_pkg: shared types and constants of the interrupt controller.
// Contents: handshake FSM state enum, control-bank register addresses,
// CTRL register bit positions and the ISR vector computation helper.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKED = 2'd2
  } intc_state_e;

  localparam logic [1:0] INTC_MASK    = 2'd0;
  localparam logic [1:0] INTC_PENDING = 2'd1;
  localparam logic [1:0] INTC_ACTIVE  = 2'd2;
  localparam logic [1:0] INTC_CTRL    = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_BUSY_BIT = 1;

  // ISR address of a source; arithmetic is 8-bit and wraps mod 256.
  function automatic logic [7:0] intc_vector(input logic [7:0] base,
                                             input logic [7:0] stride,
                                             input logic [7:0] id);
    return base + id * stride;
  endfunction

endpackage

// File: rtl/isa_pkg.sv
// isa_pkg: ISA-level constants shared between the CPU and its peripherals.
// Holds the default interrupt vector table placement used by the interrupt
// controller: ISR address of source 0 and byte distance between ISRs.
package isa_pkg;

  localparam logic [7:0] ISA_VECTOR_BASE   = 8'h80;
  localparam int         ISA_VECTOR_STRIDE = 4;

endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: CPU-facing signals of the interrupt controller.
//   int_req    - interrupt request to the CPU
//   int_ack    - CPU acknowledge
//   int_vector - ISR address of the latched source
//   reg_we/reg_addr/reg_wdata - control bank write port
//   reg_rdata  - combinational control bank read data
// master: the interrupt controller; slave: the CPU side.
interface interrupt_controller_if;
  logic       int_req;
  logic       int_ack;
  logic [7:0] int_vector;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;

  modport master (
    output int_req, int_vector, reg_rdata,
    input  int_ack, reg_we, reg_addr, reg_wdata
  );

  modport slave (
    input  int_req, int_vector, reg_rdata,
    output int_ack, reg_we, reg_addr, reg_wdata
  );
endinterface

// File: rtl/intc_priority_encoder.sv
// intc_priority_encoder: picks the lowest-index set bit of i_req.
//   i_req   - request vector (NUM_SOURCES bits)
//   o_id    - index of the lowest set bit (0 when none)
//   o_valid - 1 when any bit of i_req is set
module intc_priority_encoder #(
  parameter int NUM_SOURCES = 4,
  parameter int ID_W        = 2
) (
  input  logic [NUM_SOURCES-1:0] i_req,
  output logic [ID_W-1:0]        o_id,
  output logic                   o_valid
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    o_id    = '0;
    o_valid = 1'b0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_id    = ID_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: initiator side of the CPU interrupt handshake.
// Latches rising edges of irq_in into PENDING, qualifies them with MASK and
// the global enable, selects the lowest-index eligible source and runs a
// four-phase int_req/int_ack handshake, presenting the ISR vector.
//   clk, reset - clock, synchronous active-high reset
//   irq_in     - peripheral request lines (synchronous, rising edge = event)
//   bus        - CPU handshake and control register bank (master modport)
// Registers: 0 MASK (rw), 1 PENDING (r, w1c), 2 ACTIVE_ID (r),
//            3 CTRL (bit0 enable rw, bit1 busy r).
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int         NUM_SOURCES   = 4,
  parameter logic [7:0] VECTOR_BASE   = isa_pkg::ISA_VECTOR_BASE,
  parameter int         VECTOR_STRIDE = isa_pkg::ISA_VECTOR_STRIDE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_in,
  interrupt_controller_if.master bus
);

  localparam int ID_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  intc_state_e            r_state;
  logic [NUM_SOURCES-1:0] r_irq_prev;
  logic [NUM_SOURCES-1:0] r_pending;
  logic [NUM_SOURCES-1:0] r_mask;
  logic                   r_enable;
  logic [ID_W-1:0]        r_active;
  logic                   r_int_req;
  logic [7:0]             r_int_vector;

  intc_state_e            w_state_nxt;
  logic [NUM_SOURCES-1:0] w_edge;
  logic [NUM_SOURCES-1:0] w_eligible;
  logic [NUM_SOURCES-1:0] w_ack_clr;
  logic [NUM_SOURCES-1:0] w_w1c;
  logic [ID_W-1:0]        w_sel_id;
  logic                   w_sel_vld;
  logic                   w_take_ack;
  logic                   w_req_nxt;
  logic [ID_W-1:0]        w_active_nxt;
  logic [7:0]             w_vector_nxt;
  logic [7:0]             w_rdata;

  // irq_prev is cleared by reset, so a line already high right after reset
  // is seen as an edge.
  assign w_edge     = irq_in & ~r_irq_prev;
  assign w_eligible = r_enable ? (r_pending & r_mask) : '0;
  assign w_w1c      = (bus.reg_we && bus.reg_addr == INTC_PENDING)
                      ? bus.reg_wdata[NUM_SOURCES-1:0] : '0;

  intc_priority_encoder #(
    .NUM_SOURCES (NUM_SOURCES),
    .ID_W        (ID_W)
  ) u_prio (
    .i_req   (w_eligible),
    .o_id    (w_sel_id),
    .o_valid (w_sel_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Selection happens only in IDLE; once in REQ the request is never
  // withdrawn, whatever happens to mask, pending or enable.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_int_req;
    w_active_nxt = r_active;
    w_vector_nxt = r_int_vector;
    w_take_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_vld) begin
          w_state_nxt  = REQ;
          w_req_nxt    = 1'b1;
          w_active_nxt = w_sel_id;
          w_vector_nxt = intc_vector(VECTOR_BASE, 8'(VECTOR_STRIDE), 8'(w_sel_id));
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          w_state_nxt = ACKED;
          w_req_nxt   = 1'b0;
          w_take_ack  = 1'b1;
        end
      end
      ACKED: begin
        if (!bus.int_ack) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      w_ack_clr[i] = w_take_ack && (r_active == ID_W'(i));
    end
  end

  // Edge set is OR-ed in after the clears so a coincident set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_prev   <= '0;
      r_pending    <= '0;
      r_mask       <= '0;
      r_enable     <= 1'b0;
      r_active     <= '0;
      r_int_req    <= 1'b0;
      r_int_vector <= VECTOR_BASE;
    end else begin
      r_irq_prev   <= irq_in;
      r_pending    <= (r_pending & ~(w_ack_clr | w_w1c)) | w_edge;
      r_active     <= w_active_nxt;
      r_int_req    <= w_req_nxt;
      r_int_vector <= w_vector_nxt;
      if (bus.reg_we && bus.reg_addr == INTC_MASK)
        r_mask <= bus.reg_wdata[NUM_SOURCES-1:0];
      if (bus.reg_we && bus.reg_addr == INTC_CTRL)
        r_enable <= bus.reg_wdata[CTRL_EN_BIT];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.reg_addr)
      INTC_MASK:    w_rdata = 8'(r_mask);
      INTC_PENDING: w_rdata = 8'(r_pending);
      INTC_ACTIVE:  w_rdata = 8'(r_active);
      INTC_CTRL: begin
        w_rdata[CTRL_EN_BIT]   = r_enable;
        w_rdata[CTRL_BUSY_BIT] = (r_state != IDLE);
      end
      default: w_rdata = '0;
    endcase
  end

  assign bus.int_req    = r_int_req;
  assign bus.int_vector = r_int_vector;
  assign bus.reg_rdata  = w_rdata;

endmodule
